// File: rtl/ah_cam_loc_alloc.sv
// Hands out free CAM locations: fresh fill 0..DEPTH-1, then recycles released locations in FIFO order.
// Outputs come from registered state only. A grant updates alloc_loc and used_count one cycle later. free_ready drops when the recycle FIFO is full.
module ah_cam_loc_alloc #(
  parameter int DEPTH = 50,
  parameter int PTRW  = 6
) (
  input  logic            clk,
  input  logic            rst_an,
  output logic            alloc_valid,
  input  logic            alloc_ready,
  output logic [PTRW-1:0] alloc_loc,
  input  logic            free_valid,
  output logic            free_ready,
  input  logic [PTRW-1:0] free_loc,
  output logic [PTRW:0]   used_count,
  output logic            full,
  output logic            err_free
);

  localparam logic [PTRW:0]   DEPTH_C = (PTRW+1)'(DEPTH);
  localparam logic [PTRW:0]   ONE_C   = (PTRW+1)'(1);
  localparam logic [PTRW-1:0] LAST_C  = PTRW'(DEPTH - 1);
  localparam logic [PTRW-1:0] STEP_C  = PTRW'(1);

  logic [PTRW:0]   fresh_ptr;
  logic [PTRW:0]   fifo_cnt;
  logic [PTRW-1:0] rd_ptr;
  logic [PTRW-1:0] wr_ptr;
  logic [PTRW-1:0] fifo_mem [DEPTH];

  logic fresh_phase;
  logic alloc_fire;
  logic fifo_pop;
  logic free_acc;
  logic free_legal;

  assign fresh_phase = (fresh_ptr < DEPTH_C);
  assign alloc_valid = fresh_phase | (fifo_cnt != '0);
  assign alloc_loc   = fresh_phase ? fresh_ptr[PTRW-1:0] : fifo_mem[rd_ptr];
  assign free_ready  = (fifo_cnt != DEPTH_C);
  assign full        = (used_count == DEPTH_C);

  assign alloc_fire = alloc_valid & alloc_ready;
  assign fifo_pop   = alloc_fire & ~fresh_phase;
  assign free_acc   = free_valid & free_ready;
  // A same-cycle grant makes a release from used_count == 0 legal.
  assign free_legal = free_acc & ({1'b0, free_loc} < DEPTH_C) &
                      ((used_count != '0) | alloc_fire);

  always_ff @(posedge clk or negedge rst_an) begin
    if (!rst_an) begin
      fresh_ptr  <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_cnt   <= '0;
      used_count <= '0;
      err_free   <= 1'b0;
    end else begin
      if (alloc_fire && fresh_phase)
        fresh_ptr <= fresh_ptr + ONE_C;
      if (fifo_pop)
        rd_ptr <= (rd_ptr == LAST_C) ? '0 : rd_ptr + STEP_C;
      if (free_legal)
        wr_ptr <= (wr_ptr == LAST_C) ? '0 : wr_ptr + STEP_C;

      case ({free_legal, fifo_pop})
        2'b10:   fifo_cnt <= fifo_cnt + ONE_C;
        2'b01:   fifo_cnt <= fifo_cnt - ONE_C;
        default: fifo_cnt <= fifo_cnt;
      endcase

      case ({alloc_fire, free_legal})
        2'b10:   used_count <= used_count + ONE_C;
        2'b01:   used_count <= used_count - ONE_C;
        default: used_count <= used_count;
      endcase

      if (free_acc && !free_legal)
        err_free <= 1'b1;
    end
  end

  // Storage needs no reset: only entries counted by fifo_cnt are ever read.
  always_ff @(posedge clk) begin
    if (free_legal)
      fifo_mem[wr_ptr] <= free_loc;
  end

endmodule

// File: tb/tb_ah_cam_loc_alloc.sv
// Scoreboard bench for ah_cam_loc_alloc: queue of expected offered locations plus a small state model.
module tb_ah_cam_loc_alloc;
  localparam int DEPTH = 50;
  localparam int PTRW  = 6;

  logic            clk = 1'b0;
  logic            rst_an = 1'b1;
  logic            alloc_valid;
  logic            alloc_ready = 1'b0;
  logic [PTRW-1:0] alloc_loc;
  logic            free_valid = 1'b0;
  logic            free_ready;
  logic [PTRW-1:0] free_loc = '0;
  logic [PTRW:0]   used_count;
  logic            full;
  logic            err_free;

  int n_chk  = 0;
  int n_fail = 0;
  bit mon_en = 1'b0;

  int q[$];
  int m_used, m_fifo, m_fresh;
  bit m_err;

  ah_cam_loc_alloc #(.DEPTH(DEPTH), .PTRW(PTRW)) dut (
    .clk         (clk),
    .rst_an      (rst_an),
    .alloc_valid (alloc_valid),
    .alloc_ready (alloc_ready),
    .alloc_loc   (alloc_loc),
    .free_valid  (free_valid),
    .free_ready  (free_ready),
    .free_loc    (free_loc),
    .used_count  (used_count),
    .full        (full),
    .err_free    (err_free)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    for (int i = 0; i < DEPTH; i++) q.push_back(i);
    m_used  = 0;
    m_fifo  = 0;
    m_fresh = DEPTH;
    m_err   = 1'b0;
  endtask

  // Asserts reset between edges and checks that outputs clear asynchronously.
  task automatic do_reset();
    alloc_ready = 1'b0;
    free_valid  = 1'b0;
    free_loc    = '0;
    rst_an      = 1'b0;
    #1;
    chk("rst_alloc_valid", alloc_valid, 1);
    chk("rst_alloc_loc",   alloc_loc,   0);
    chk("rst_free_ready",  free_ready,  1);
    chk("rst_used_count",  used_count,  0);
    chk("rst_full",        full,        0);
    chk("rst_err_free",    err_free,    0);
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_an = 1'b1;
    mon_en = 1'b1;
  endtask

  task automatic cyc(input bit ar, input bit fv, input int fl);
    alloc_ready = ar;
    free_valid  = fv;
    free_loc    = PTRW'(fl);
    @(posedge clk);
    #1;
    alloc_ready = 1'b0;
    free_valid  = 1'b0;
  endtask

  // Compare outputs mid-cycle, then apply this cycle's handshakes to the model.
  always @(negedge clk) begin
    if (rst_an && mon_en) begin
      bit exp_valid, a_fire, f_acc, f_ok;
      exp_valid = (q.size() != 0);
      chk("alloc_valid", alloc_valid, int'(exp_valid));
      if (exp_valid) chk("alloc_loc", alloc_loc, q[0]);
      chk("used_count", used_count, m_used);
      chk("full", full, int'(m_used == DEPTH));
      chk("free_ready", free_ready, int'(m_fifo != DEPTH));
      chk("err_free", err_free, int'(m_err));
      chk("invariant", int'(dut.used_count) + int'(dut.fifo_cnt) + DEPTH - int'(dut.fresh_ptr), DEPTH);

      a_fire = exp_valid && alloc_ready;
      f_acc  = free_valid && (m_fifo != DEPTH);
      f_ok   = f_acc && (int'(free_loc) < DEPTH) && (m_used != 0 || a_fire);
      if (a_fire) begin
        void'(q.pop_front());
        if (m_fresh > 0) m_fresh--; else m_fifo--;
        m_used++;
      end
      if (f_ok) begin
        q.push_back(int'(free_loc));
        m_fifo++;
        m_used--;
      end else if (f_acc) begin
        m_err = 1'b1;
      end
    end
  end

  initial begin
    #2;
    do_reset();
    // Release while nothing is allocated.
    cyc(0, 1, 0);
    chk("err_empty_free", err_free, 1);
    chk("used_empty_free", used_count, 0);

    do_reset();
    for (int i = 0; i < DEPTH; i++) cyc(1, 0, 0);
    chk("fill_full", full, 1);
    chk("fill_valid", alloc_valid, 0);
    chk("fill_used", used_count, DEPTH);

    cyc(0, 1, 7);
    chk("rel7_valid", alloc_valid, 1);
    cyc(0, 1, 3);
    cyc(0, 1, 49);
    chk("rel_used", used_count, 47);
    chk("rel_first_loc", alloc_loc, 7);
    for (int i = 0; i < 3; i++) cyc(1, 0, 0);
    chk("realloc_full", full, 1);

    // Release and request in the same cycle while full: no bypass.
    cyc(1, 1, 12);
    chk("nobypass_loc", alloc_loc, 12);
    chk("nobypass_valid", alloc_valid, 1);
    cyc(1, 0, 0);
    chk("nobypass_full", full, 1);

    cyc(0, 1, 55);
    chk("err_oor", err_free, 1);
    chk("oor_used", used_count, DEPTH);

    // Pointer wrap with random recycled indices.
    cyc(0, 1, $urandom_range(0, DEPTH-1));
    for (int i = 0; i < 119; i++) cyc(1, 1, $urandom_range(0, DEPTH-1));
    cyc(1, 0, 0);
    chk("wrap_full", full, 1);
    chk("wrap_queue_empty", q.size(), 0);

    do_reset();
    for (int i = 0; i < 30; i++) cyc(1, 0, 0);
    chk("mid_used", used_count, 30);
    do_reset();
    chk("post_rst_loc", alloc_loc, 0);
    cyc(1, 0, 0);
    chk("post_rst_next", alloc_loc, 1);
    chk("post_rst_used", used_count, 1);
    cyc(0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ah_cam_loc_alloc.md
# ah_cam_loc_alloc

Location allocator for the AH CAM. It hands out free CAM entry indices on a valid/ready port so the CAM write path knows which `cam_loc` to fill. It starts with a one-time sequential fill of locations 0..DEPTH-1, then recycles locations released by snoop-match through an internal circular free list. It sits directly upstream of the CAM storage write logic and consumes the CAM's freed-location output.

## Interface
- `DEPTH`, 50: number of CAM locations; legal range 2..64.
- `PTRW`, 6: location index width; must equal ceil(log2(DEPTH)).
- `clk`  in  1: clock.
- `rst_an`  in  1: asynchronous, active-low reset.
- `alloc_valid`  out  1: a free location is offered on `alloc_loc`.
- `alloc_ready`  in  1: consumer (CAM write) takes the offered location.
- `alloc_loc`  out  PTRW: offered location index.
- `free_valid`  in  1: the CAM releases a location.
- `free_ready`  out  1: allocator accepts the release.
- `free_loc`  in  PTRW: released location index.
- `used_count`  out  PTRW+1: number of locations currently allocated.
- `full`  out  1: `used_count == DEPTH`.
- `err_free`  out  1: sticky; an illegal release was dropped.

## Operation
- State:
  - `fresh_ptr` (PTRW+1 bits, 0..DEPTH).
  - Recycle FIFO of DEPTH entries × PTRW: `rd_ptr` and `wr_ptr` in 0..DEPTH-1, plus `fifo_cnt` in 0..DEPTH.
  - `used_count`.
  - `err_free`.
- Source select:
  - While `fresh_ptr < DEPTH`: `alloc_loc = fresh_ptr[PTRW-1:0]` and `alloc_valid = 1`. Fresh locations always take priority.
  - Otherwise: `alloc_loc = fifo[rd_ptr]` and `alloc_valid = (fifo_cnt != 0)`.
- Allocate handshake (`alloc_valid & alloc_ready`):
  - Fresh source: `fresh_ptr` increments.
  - Recycle source: `rd_ptr` advances, `fifo_cnt` decrements.
  - `used_count` increments.
- Release:
  - `free_ready = (fifo_cnt != DEPTH)`.
  - A legal release (`free_valid & free_ready & free_loc < DEPTH & used_count != 0`) writes `fifo[wr_ptr] = free_loc`, advances `wr_ptr`, increments `fifo_cnt` and decrements `used_count`.
- Illegal release (`free_loc >= DEPTH`, or `used_count == 0` with no simultaneous allocate):
  - Dropped: no state change except `err_free <= 1`.
  - `err_free` is cleared only by reset.
  - Double-free of the same index is not detected.
- Pointer wrap: `rd_ptr` and `wr_ptr` go from DEPTH-1 to 0. Modulo-DEPTH, not modulo-2^PTRW.
- Simultaneous allocate and legal release in one cycle:
  - Both take effect; `used_count` is unchanged.
  - With `fifo_cnt == 0`, the released index is **not** bypassed to `alloc_loc`; it becomes offered the next cycle.
  - The `used_count == 0` legality test uses the pre-cycle value plus the same-cycle allocate. A release coinciding with an allocate from `used_count == 0` is legal.
- Invariant: `used_count + fifo_cnt + (DEPTH - fresh_ptr) == DEPTH`. Assertions in the bench check it every cycle.
- `full = (used_count == DEPTH)`, which is equivalent to `alloc_valid == 0` after the fresh phase.

## Timing
- All state is registered on `posedge clk` and reset asynchronously by `rst_an` low.
- Outputs `alloc_valid`, `alloc_loc`, `free_ready` and `full` are combinational from registered state only. There is no input-to-output combinational path.
- Reset values:
  - `alloc_valid = 1`, `alloc_loc = 0`, `free_ready = 1`.
  - `used_count = 0`, `full = 0`, `err_free = 0`.
  - `fresh_ptr = 0`, `rd_ptr = 0`, `wr_ptr = 0`, `fifo_cnt = 0`.
- Latency:
  - An allocate at cycle N updates `alloc_loc` and `used_count` at N+1.
  - A release at cycle N is visible in `used_count` at N+1. The location is offerable at N+1 if the FIFO was empty and the fresh phase is over.
- Throughput: one allocate and one release per cycle sustained.
- `alloc_loc` is stable while `alloc_valid & ~alloc_ready`.
- Reset mid-operation: all allocations are forgotten; the next cycle after deassert behaves as after power-on reset. The CAM contents are the consumer's responsibility.

## Test plan
- Reset release, `alloc_ready = 1` for 50 cycles, no frees:
  - `alloc_loc` = 0,1,…,49 on consecutive cycles.
  - Then `alloc_valid = 0`, `full = 1`, `used_count = 50`.
- From full, release 7, 3, 49 on three cycles:
  - `used_count` = 47.
  - `alloc_valid` rises the cycle after the first release.
  - Allocates return 7, 3, 49 in that order.
- From full, release 12 and allocate in the same cycle:
  - The allocate is not granted that cycle (`alloc_valid = 0`).
  - Next cycle `alloc_loc = 12`; allocating it restores `full = 1`.
- Pointer wrap: from full, run 120 cycles of release-then-allocate with pseudo-random indices:
  - Allocated order matches release order exactly.
  - The invariant holds every cycle.
- Illegal releases:
  - `free_loc = 55`: dropped, `err_free = 1`, `used_count` unchanged.
  - After reset, `free_loc = 0` with `used_count == 0`: dropped, `err_free = 1`.
- Assert `rst_an` low with `used_count = 30`:
  - All outputs return to reset values asynchronously.
  - After deassert, the first allocate returns 0.
